// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its consumers.
//   INSTR_W            instruction word width
//   OPCODE_MSB/LSB     opcode field position (bit 0 = MSB of the word)
//   PC_STEP            byte increment between sequential fetches
//   fetch_state_e      fetch control state encodings
package instr_fetch_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_MSB = 0;
    localparam int unsigned OPCODE_LSB = 5;
    localparam int unsigned OPCODE_W   = OPCODE_LSB - OPCODE_MSB + 1;
    localparam int unsigned PC_STEP    = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [0:OPCODE_W-1] opcode_of(input logic [0:INSTR_W-1] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous DEPTH x W FIFO with flush, used for the prefetch queue and
// the per-request PC tag queue.
//   clk, rst_n   clock / asynchronous active-low reset
//   flush        empty the FIFO this cycle (overrides push/pop)
//   push         write push_data
//   pop          advance the head (ignored when empty)
//   head_data    registered head entry
//   count        number of valid entries
module instr_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_push  = push & ~flush;
        do_pop   = pop & (count_q != '0) & ~flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Upstream credit accounting must never let a write land on a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_n && push && !flush) begin
            assert (count_q != CW'(DEPTH));
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the decode unit.
// Owns the PC, issues word reads, buffers returned words in a prefetch
// queue and restarts on redirect, discarding stale in-flight responses.
//   fetch_en                     allow new requests
//   redirect_valid/redirect_pc   restart fetch at redirect_pc (low 2 bits ignored)
//   imem_req/imem_addr           read request to instruction memory
//   imem_rvalid/imem_rdata       in-order read responses
//   instr_valid/instr/instr_pc   head of prefetch queue to decode
//   instr_ready                  decode consumes the head word
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned    AW       = 32,
    parameter int unsigned    DEPTH    = 2,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    input  logic          redirect_valid,
    input  logic [0:AW-1] redirect_pc,
    output logic          imem_req,
    output logic [0:AW-1] imem_addr,
    input  logic          imem_rvalid,
    input  logic [0:31]   imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [0:31]   instr,
    output logic [0:AW-1] instr_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned QW = INSTR_W + AW;

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] q_count, tag_count;
    logic [QW-1:0] q_head;
    logic [AW-1:0] tag_head;
    logic          issue, accept, q_pop;
    logic [CW-1:0] in_flight_after;

    always_comb begin
        // Queued words count against credit so a response always has a slot.
        issue = rst_n & fetch_en & ~redirect_valid &
                (({1'b0, q_count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH));
        accept = imem_rvalid & (drop_q == '0) & ~redirect_valid;
        q_pop  = (q_count != '0) & instr_ready;

        in_flight_after = outstanding_q - CW'(imem_rvalid);
        outstanding_d   = in_flight_after + CW'(issue);

        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~AW'(3);
        end else if (issue) begin
            pc_d = pc_q + AW'(PC_STEP);
        end

        // Every read still in flight at a redirect belongs to the old stream,
        // including reads already marked stale by an earlier redirect.
        drop_d = drop_q;
        if (redirect_valid) begin
            drop_d = in_flight_after;
        end else if (imem_rvalid && drop_q != '0) begin
            drop_d = drop_q - CW'(1);
        end

        state_d = state_q;
        if (redirect_valid) begin
            if (in_flight_after != '0) begin
                state_d = FETCH_DRAIN;
            end else begin
                state_d = fetch_en ? FETCH_RUN : FETCH_IDLE;
            end
        end else begin
            case (state_q)
                FETCH_IDLE:  if (fetch_en) state_d = FETCH_RUN;
                FETCH_RUN:   if (!fetch_en) state_d = FETCH_IDLE;
                FETCH_DRAIN: if (drop_d == '0) state_d = fetch_en ? FETCH_RUN : FETCH_IDLE;
                default:     state_d = FETCH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH_IDLE;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    instr_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (QW)
    ) u_instr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (accept),
        .push_data ({imem_rdata, tag_head}),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count)
    );

    instr_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (AW)
    ) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (issue),
        .push_data (pc_q),
        .pop       (accept),
        .head_data (tag_head),
        .count     (tag_count)
    );

    // Tags exist only for live (non-stale) reads.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (tag_count == outstanding_q - drop_q);
        end
    end

    assign imem_req    = issue;
    assign imem_addr   = pc_q;
    assign instr_valid = (q_count != '0);
    assign instr       = q_head[QW-1:AW];
    assign instr_pc    = q_head[AW-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;

    always #5 clk = ~clk;

    instr_fetch #(
        .AW       (32),
        .DEPTH    (2),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] epc;
        int          epoch;
        int          due;
    } req_t;
    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    req_t        pending[$];
    exp_t        sb[$];
    int          cyc = 0;
    int          epoch = 0;
    int          lat = 1;
    logic [31:0] exp_pc = '0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_popped = 0;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h11AA5800 ^ (a * 32'h9E3779B1);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    // One clock cycle: memory response, negedge scoreboard compare, model update.
    task automatic step();
        logic exp_req;
        req_t p;
        req_t r;
        exp_t e;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memword(pending[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
        s_instr = instr; s_pc = instr_pc;

        exp_req = fetch_en && !redirect_valid && (sb.size() + pending.size() < 2);
        n_vec++;
        if (imem_req !== exp_req) begin
            n_err++;
            $display("FAIL imem_req cyc=%0d got %b want %b", cyc, imem_req, exp_req);
        end
        if (imem_req === 1'b1) begin
            n_vec++;
            if (imem_addr !== exp_pc) begin
                n_err++;
                $display("FAIL imem_addr cyc=%0d got %h want %h", cyc, imem_addr, exp_pc);
            end
        end
        n_vec++;
        if (instr_valid !== (sb.size() > 0)) begin
            n_err++;
            $display("FAIL instr_valid cyc=%0d got %b want %b", cyc, instr_valid, sb.size() > 0);
        end
        if (instr_valid === 1'b1 && sb.size() > 0) begin
            n_vec++;
            if (instr !== sb[0].data || instr_pc !== sb[0].pc) begin
                n_err++;
                $display("FAIL instr_word cyc=%0d got %h@%h want %h@%h",
                         cyc, instr, instr_pc, sb[0].data, sb[0].pc);
            end
            if (instr_ready) begin
                void'(sb.pop_front());
                n_popped++;
            end
        end
        if (imem_rvalid) begin
            p = pending.pop_front();
            if (!redirect_valid && p.epoch == epoch) begin
                e.data = memword(p.epc);
                e.pc   = p.epc;
                sb.push_back(e);
            end
        end
        if (redirect_valid) begin
            sb.delete();
            epoch++;
            exp_pc = redirect_pc & ~32'd3;
        end
        if (imem_req === 1'b1) begin
            r.addr  = imem_addr;
            r.epc   = exp_pc;
            r.epoch = epoch;
            r.due   = cyc + lat;
            pending.push_back(r);
            exp_pc  = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        imem_rvalid = 1'b0;
        redirect_valid = 1'b0;
        pending.delete();
        sb.delete();
        exp_pc = '0;
        epoch++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc += 2;
    endtask

    task automatic test_reset();
        fetch_en = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        n_vec += 5;
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", imem_req); end
        if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", imem_addr); end
        if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", instr); end
        if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", instr_pc); end
        fetch_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        repeat (3) step();
    endtask

    task automatic test_stream();
        int n;
        lat = 1; fetch_en = 1'b1; instr_ready = 1'b1;
        n = 0;
        do begin step(); n++; end while (!s_valid && n < 10);
        n_vec++;
        if (s_valid !== 1'b1 || s_instr !== 32'h11AA5800 || s_pc !== 32'h0) begin
            n_err++;
            $display("FAIL first_word got v=%b %h@%h want 1 11aa5800@00000000", s_valid, s_instr, s_pc);
        end
        n_popped = 0;
        repeat (20) step();
        n_vec++;
        if (n_popped < 13) begin
            n_err++;
            $display("FAIL stream_rate got %0d words want >=13", n_popped);
        end
    endtask

    task automatic test_stall();
        int nreq;
        apply_reset();
        lat = 1; fetch_en = 1'b1; instr_ready = 1'b0;
        nreq = 0;
        repeat (6) begin
            step();
            if (s_req) nreq++;
        end
        n_vec += 3;
        if (nreq != 2) begin n_err++; $display("FAIL stall_reqs got %0d want 2", nreq); end
        if (s_req !== 1'b0) begin n_err++; $display("FAIL stall_req_low got %b want 0", s_req); end
        if (s_valid !== 1'b1 || s_instr !== 32'h11AA5800) begin
            n_err++;
            $display("FAIL stall_hold got v=%b %h want 1 11aa5800", s_valid, s_instr);
        end
        instr_ready = 1'b1;
        n_popped = 0;
        repeat (12) step();
        n_vec++;
        if (n_popped < 6) begin n_err++; $display("FAIL stall_resume got %0d words want >=6", n_popped); end
    endtask

    task automatic test_latency3();
        lat = 3; fetch_en = 1'b1;
        repeat (40) begin
            instr_ready = ($urandom_range(3) != 0);
            step();
            n_vec++;
            if (pending.size() > 2) begin
                n_err++;
                $display("FAIL outstanding got %0d want <=2", pending.size());
            end
        end
        instr_ready = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_redirect();
        int n;
        lat = 3; fetch_en = 1'b1; instr_ready = 1'b1;
        n = 0;
        while (pending.size() != 2 && n < 20) begin step(); n++; end
        n_vec++;
        if (pending.size() != 2) begin n_err++; $display("FAIL redir_setup got %0d want 2 outstanding", pending.size()); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
        step();
        n_vec += 2;
        if (dut.drop_q !== 2'(pending.size())) begin
            n_err++;
            $display("FAIL redir_drop got %0d want %0d", dut.drop_q, pending.size());
        end
        if ((pending.size() > 0) && (dut.state_q !== FETCH_DRAIN)) begin
            n_err++;
            $display("FAIL redir_state got %0d want DRAIN", dut.state_q);
        end
        n = 0;
        do begin step(); n++; end while (!s_valid && n < 20);
        n_vec++;
        if (s_valid !== 1'b1 || s_pc !== 32'h40) begin
            n_err++;
            $display("FAIL redir_target got v=%b pc=%h want 1 pc=00000040", s_valid, s_pc);
        end
        repeat (6) step();
    endtask

    task automatic test_redirect_collide();
        int n;
        lat = 2; fetch_en = 1'b1; instr_ready = 1'b1;
        n = 0;
        while (!(pending.size() > 1 && pending[0].due <= cyc) && n < 20) begin step(); n++; end
        n_vec++;
        if (!(pending.size() > 1)) begin n_err++; $display("FAIL collide_setup got %0d want >1 outstanding", pending.size()); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        n = 0;
        do begin step(); n++; end while (!s_valid && n < 20);
        n_vec++;
        if (s_valid !== 1'b1 || s_pc !== 32'h200) begin
            n_err++;
            $display("FAIL collide_target got v=%b pc=%h want 1 pc=00000200", s_valid, s_pc);
        end
        repeat (8) step();
        n_vec++;
        if (dut.drop_q !== 2'd0) begin n_err++; $display("FAIL collide_drop got %0d want 0", dut.drop_q); end
    endtask

    task automatic test_async_reset();
        int n;
        lat = 1; fetch_en = 1'b1; instr_ready = 1'b1;
        repeat (7) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec += 3;
        if (instr_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got %b want 0", instr_valid); end
        if (imem_addr !== 32'h0) begin n_err++; $display("FAIL areset_addr got %h want 0", imem_addr); end
        if (imem_req !== 1'b0) begin n_err++; $display("FAIL areset_req got %b want 0", imem_req); end
        imem_rvalid = 1'b0;
        pending.delete();
        sb.delete();
        exp_pc = '0;
        epoch++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        n = 0;
        do begin step(); n++; end while (!s_req && n < 10);
        n_vec++;
        if (s_req !== 1'b1 || s_addr !== 32'h0) begin
            n_err++;
            $display("FAIL areset_restart got req=%b addr=%h want 1 00000000", s_req, s_addr);
        end
        repeat (10) step();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_latency3();
        test_redirect();
        test_redirect_collide();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
